// File: rtl/instr_enc_if.sv
`timescale 1ns/1ps
// instr_enc_if: decoded-field input handshake and encoded-word output handshake of instr_encoder.
// master drives fields and takes words; slave is the encoder.
interface instr_enc_if #(
    parameter int ADDR_W = 10
);
    logic              in_valid;
    logic              in_ready;
    logic [1:0]        kind;
    logic [4:0]        rd;
    logic [4:0]        rs1;
    logic [4:0]        rs2;
    logic [31:0]       imm;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out;
    logic [ADDR_W-1:0] addr;

    modport master (
        output in_valid, kind, rd, rs1, rs2, imm, out_ready,
        input  in_ready, out_valid, out, addr
    );

    modport slave (
        input  in_valid, kind, rd, rs1, rs2, imm, out_ready,
        output in_ready, out_valid, out, addr
    );
endinterface

// File: rtl/instr_encoder.sv
`timescale 1ns/1ps
// instr_encoder: packs lw/sw/beq/addi fields into RV32I words behind a one-entry output register.
// Define ENCODER_RANGE_CHECK_EN to reject out-of-range immediates (nop substitution, ERR/ERR_CNT).
module instr_encoder #(
    parameter int                ADDR_W = 10,
    parameter logic [ADDR_W-1:0] BASE   = '0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    instr_enc_if.slave bus,
    output logic       err,
    output logic [7:0] err_cnt
);
    localparam logic [31:0] NOP      = 32'h0000_0013;
    localparam logic [1:0]  KIND_LW   = 2'd0;
    localparam logic [1:0]  KIND_SW   = 2'd1;
    localparam logic [1:0]  KIND_BEQ  = 2'd2;
    localparam logic [1:0]  KIND_ADDI = 2'd3;

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

    state_t            state_reg, state_next;
    logic [31:0]       out_reg, out_next;
    logic [ADDR_W-1:0] addr_reg, addr_next;
    logic              first_reg, first_next;
    logic              in_ready;
    logic              accept;
    logic              reject;
    logic [31:0]       word;

    function automatic logic [31:0] pack(
        input logic [1:0]  kind,
        input logic [4:0]  rd,
        input logic [4:0]  rs1,
        input logic [4:0]  rs2,
        input logic [12:0] imm
    );
        pack = NOP;
        case (kind)
            KIND_LW:   pack = {imm[11:0], rs1, 3'b010, rd, 7'b0000011};
            KIND_SW:   pack = {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
            KIND_BEQ:  pack = {imm[12], imm[10:5], rs2, rs1, 3'b000, imm[4:1], imm[11], 7'b1100011};
            KIND_ADDI: pack = {imm[11:0], rs1, 3'b000, rd, 7'b0010011};
            default:   pack = NOP;
        endcase
    endfunction

    // CLR wins over any transfer, so the input is refused while it is high.
    assign in_ready = ((state_reg == EMPTY) || bus.out_ready) && !clr;
    assign accept   = bus.in_valid && in_ready;
    assign word     = reject ? NOP : pack(bus.kind, bus.rd, bus.rs1, bus.rs2, bus.imm[12:0]);

    always_comb begin
        state_next = state_reg;
        out_next   = out_reg;
        addr_next  = addr_reg;
        first_next = first_reg;
        if (clr) begin
            state_next = EMPTY;
            addr_next  = BASE;
            first_next = 1'b1;
        end else if (accept) begin
            state_next = FULL;
            out_next   = word;
            addr_next  = first_reg ? BASE : addr_reg + ADDR_W'(4);
            first_next = 1'b0;
        end else if ((state_reg == FULL) && bus.out_ready) begin
            state_next = EMPTY;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= EMPTY;
            out_reg   <= '0;
            addr_reg  <= BASE;
            first_reg <= 1'b1;
        end else begin
            state_reg <= state_next;
            out_reg   <= out_next;
            addr_reg  <= addr_next;
            first_reg <= first_next;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = (state_reg == FULL);
    assign bus.out       = out_reg;
    assign bus.addr      = addr_reg;

`ifdef ENCODER_RANGE_CHECK_EN
    logic       err_reg, err_next;
    logic [7:0] cnt_reg, cnt_next;

    function automatic logic imm_ok(input logic [1:0] kind, input logic signed [31:0] imm);
        if (kind == KIND_BEQ)
            imm_ok = (imm >= -32'sd4096) && (imm <= 32'sd4094) && !imm[0];
        else
            imm_ok = (imm >= -32'sd2048) && (imm <= 32'sd2047);
    endfunction

    assign reject = !imm_ok(bus.kind, bus.imm);

    always_comb begin
        err_next = err_reg;
        cnt_next = cnt_reg;
        if (clr) begin
            err_next = 1'b0;
            cnt_next = '0;
        end else if (accept && reject) begin
            err_next = 1'b1;
            cnt_next = (cnt_reg == 8'hFF) ? cnt_reg : cnt_reg + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_reg <= 1'b0;
            cnt_reg <= '0;
        end else begin
            err_reg <= err_next;
            cnt_reg <= cnt_next;
        end
    end

    assign err     = err_reg;
    assign err_cnt = cnt_reg;
`else
    // Without checking, high immediate bits are silently truncated.
    logic unused_imm_hi;
    assign unused_imm_hi = ^bus.imm[31:13];
    assign reject        = 1'b0;
    assign err           = 1'b0;
    assign err_cnt       = '0;
`endif
endmodule

// File: tb/tb_instr_encoder.sv
`timescale 1ns/1ps
// tb_instr_encoder: directed and randomized checks of instr_encoder against a field-level reference
// encoder and a transaction-level model of the output register, address counter and error count.
module tb_instr_encoder;
    localparam int AW   = 10;
    localparam int BASE = 0;
    localparam int WRAP = 1 << AW;
`ifdef ENCODER_RANGE_CHECK_EN
    localparam bit RANGE_EN = 1'b1;
`else
    localparam bit RANGE_EN = 1'b0;
`endif

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       clr   = 1'b0;
    logic       err;
    logic [7:0] err_cnt;

    instr_enc_if #(.ADDR_W(AW)) bus ();

    instr_encoder #(.ADDR_W(AW), .BASE(AW'(BASE))) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (clr),
        .bus     (bus),
        .err     (err),
        .err_cnt (err_cnt)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    bit          m_valid;
    bit          m_first;
    bit          m_err;
    int          m_addr;
    int          m_cnt;
    logic [31:0] m_out;
    int          bnd [8] = '{-2048, 2047, 2048, -2049, -4096, 4094, 4095, -4098};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    function automatic bit imm_bad(int kind, int imm);
        if (kind == 2)
            return RANGE_EN && (imm < -4096 || imm > 4094 || (imm % 2) != 0);
        return RANGE_EN && (imm < -2048 || imm > 2047);
    endfunction

    function automatic logic [31:0] ref_word(int kind, int rd, int rs1, int rs2, int imm);
        logic [31:0] u;
        u = imm;
        if (imm_bad(kind, imm)) return 32'h0000_0013;
        case (kind)
            0: return ((u & 32'hFFF) << 20) | (rs1 << 15) | (2 << 12) | (rd << 7) | 32'h03;
            1: return (((u >> 5) & 32'h7F) << 25) | (rs2 << 20) | (rs1 << 15) | (2 << 12)
                      | ((u & 32'h1F) << 7) | 32'h23;
            2: return (((u >> 12) & 32'h1) << 31) | (((u >> 5) & 32'h3F) << 25) | (rs2 << 20)
                      | (rs1 << 15) | (((u >> 1) & 32'hF) << 8) | (((u >> 11) & 32'h1) << 7) | 32'h63;
            default: return ((u & 32'hFFF) << 20) | (rs1 << 15) | (rd << 7) | 32'h13;
        endcase
    endfunction

    function automatic int rand_imm();
        case ($urandom_range(0, 4))
            0: return int'($urandom_range(0, 4095)) - 2048;
            1: return int'($urandom_range(0, 8191)) - 4096;
            2: return bnd[$urandom_range(0, 7)];
            3: return int'($urandom);
            default: return (int'($urandom_range(0, 2047)) - 1024) * 2;
        endcase
    endfunction

    task automatic model_reset();
        m_valid = 1'b0;
        m_first = 1'b1;
        m_err   = 1'b0;
        m_addr  = BASE;
        m_cnt   = 0;
        m_out   = '0;
    endtask

    task automatic send(int k, int rd, int rs1, int rs2, int imm);
        bus.in_valid = 1'b1;
        bus.kind     = 2'(k);
        bus.rd       = 5'(rd);
        bus.rs1      = 5'(rs1);
        bus.rs2      = 5'(rs2);
        bus.imm      = imm;
    endtask

    task automatic send_rand();
        send(int'($urandom_range(0, 3)), int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
             int'($urandom_range(0, 31)), rand_imm());
    endtask

    // Called just after a falling edge with inputs set; returns at the next falling edge.
    task automatic cycle();
        bit exp_rdy;
        int imm_i;
        #1;
        exp_rdy = (!m_valid || bus.out_ready) && !clr;
        check("in_ready", 32'(bus.in_ready), 32'(exp_rdy));
        check("out_valid", 32'(bus.out_valid), 32'(m_valid));
        if (m_valid) check("out", bus.out, m_out);
        check("addr", 32'(bus.addr), m_addr);
        check("err", 32'(err), 32'(m_err));
        check("err_cnt", 32'(err_cnt), m_cnt);
        @(posedge clk);
        if (m_valid && bus.out_ready && !clr)
            $display("word addr=%03h data=%08h", m_addr, m_out);
        if (clr) begin
            m_valid = 1'b0;
            m_first = 1'b1;
            m_addr  = BASE;
            m_err   = 1'b0;
            m_cnt   = 0;
        end else if (bus.in_valid && exp_rdy) begin
            imm_i  = $signed(bus.imm);
            m_out  = ref_word(int'(bus.kind), int'(bus.rd), int'(bus.rs1), int'(bus.rs2), imm_i);
            m_addr = m_first ? BASE : (m_addr + 4) % WRAP;
            m_first = 1'b0;
            m_valid = 1'b1;
            if (imm_bad(int'(bus.kind), imm_i)) begin
                m_err = 1'b1;
                if (m_cnt < 255) m_cnt++;
            end
        end else if (m_valid && bus.out_ready) begin
            m_valid = 1'b0;
        end
        @(negedge clk);
    endtask

    task automatic pulse_clr();
        clr = 1'b1;
        bus.in_valid = 1'b0;
        cycle();
        clr = 1'b0;
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.kind      = '0;
        bus.rd        = '0;
        bus.rs1       = '0;
        bus.rs2       = '0;
        bus.imm       = '0;
        bus.out_ready = 1'b1;
        model_reset();
        repeat (2) @(negedge clk);
        check("rst_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out", bus.out, 32'd0);
        check("rst_addr", 32'(bus.addr), BASE);
        check("rst_err", 32'(err), 32'd0);
        check("rst_cnt", 32'(err_cnt), 32'd0);
        rst_n = 1'b1;

        send(0, 1, 2, 0, 4);
        cycle();
        bus.in_valid = 1'b0;
        check("lw_word", bus.out, 32'h00412083);
        check("lw_addr", 32'(bus.addr), 32'h000);
        check("lw_valid", 32'(bus.out_valid), 32'd1);

        pulse_clr();
        send(1, 0, 2, 3, -32);
        cycle();
        check("sw_word", bus.out, 32'hFE312023);
        check("sw_addr", 32'(bus.addr), 32'h000);
        send(2, 0, 1, 2, -16);
        cycle();
        check("beq_word", bus.out, 32'hFE2088E3);
        check("beq_addr", 32'(bus.addr), 32'h004);
        check("beq_valid", 32'(bus.out_valid), 32'd1);
        bus.in_valid = 1'b0;
        cycle();

        pulse_clr();
        bus.out_ready = 1'b0;
        send(3, 5, 0, 0, -1);
        cycle();
        bus.in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            check("hold_word", bus.out, 32'hFFF00293);
            check("hold_ready", 32'(bus.in_ready), 32'd0);
            check("hold_addr", 32'(bus.addr), 32'h000);
        end
        bus.out_ready = 1'b1;
        cycle();
        check("release_valid", 32'(bus.out_valid), 32'd0);

`ifdef ENCODER_RANGE_CHECK_EN
        pulse_clr();
        send(0, 1, 2, 0, 2048);
        cycle();
        check("lw_range_nop", bus.out, 32'h00000013);
        send(2, 0, 1, 2, 3);
        cycle();
        bus.in_valid = 1'b0;
        check("beq_odd_nop", bus.out, 32'h00000013);
        check("range_err", 32'(err), 32'd1);
        check("range_cnt", 32'(err_cnt), 32'd2);
        pulse_clr();
        check("clr_err", 32'(err), 32'd0);
        check("clr_cnt", 32'(err_cnt), 32'd0);
        send(0, 1, 2, 0, 4);
        cycle();
        bus.in_valid = 1'b0;
        check("clr_addr", 32'(bus.addr), 32'h000);
        for (int i = 0; i < 260; i++) begin
            send(3, 1, 1, 0, 5000 + i);
            cycle();
        end
        bus.in_valid = 1'b0;
        check("cnt_sat", 32'(err_cnt), 32'd255);
`endif

        pulse_clr();
        for (int i = 1; i <= 257; i++) begin
            send_rand();
            cycle();
            if (i == 256) check("wrap_256", 32'(bus.addr), 32'h3FC);
            if (i == 257) check("wrap_257", 32'(bus.addr), 32'h000);
        end

        for (int i = 0; i < 1500; i++) begin
            send_rand();
            bus.in_valid  = ($urandom_range(0, 3) != 0);
            bus.out_ready = ($urandom_range(0, 9) < 7);
            clr           = ($urandom_range(0, 49) == 0);
            cycle();
        end
        clr = 1'b0;

        bus.out_ready = 1'b0;
        send(3, 5, 0, 0, -1);
        cycle();
        bus.in_valid = 1'b0;
        check("pre_rst_valid", 32'(bus.out_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_valid", 32'(bus.out_valid), 32'd0);
        check("arst_addr", 32'(bus.addr), BASE);
        check("arst_out", bus.out, 32'd0);
        check("arst_cnt", 32'(err_cnt), 32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        send(0, 1, 2, 0, 4);
        cycle();
        bus.in_valid = 1'b0;
        check("post_rst_addr", 32'(bus.addr), BASE);
        check("post_rst_word", bus.out, 32'h00412083);
        cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
